gmii_rx_framer: RTL and testbench

//  Upstream stage of the DMA receive path. Takes GMII receive bytes and strips the preamble/SFD.

---
 rtl/gmii_rx_framer_if.sv | 12 +
 rtl/gmii_rx_framer.sv | 175 +++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_rx_framer_if.sv
// FIFO write-side bundle between the GMII receive framer and the phy FIFO.
// phy_wr_en qualifies phy_din for exactly one sys_clk cycle; there is no per-word ready,
// the writer only starts a frame when phy_afull is low and treats phy_full as a lost word.
interface gmii_rx_framer_if;
  logic [17:0] phy_din;
  logic        phy_wr_en;
  logic        phy_full;
  logic        phy_afull;

  modport master (output phy_din, output phy_wr_en, input phy_full, input phy_afull);
  modport slave  (input phy_din, input phy_wr_en, output phy_full, output phy_afull);
endinterface

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, prefixes a timestamp/sequence header and packs
// frame bytes into tagged 18-bit FIFO words, terminating every accepted frame.
module gmii_rx_framer #(
  parameter int MAX_FRAME = 1522,
  parameter int DLY       = 6
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [63:0] global_counter,
  gmii_rx_framer_if.master phy,
  output logic [7:0]  phy_rx_count,
  output logic [15:0] err_count,
  output logic [15:0] drop_count,
  output logic [2:0]  o_dbg_state
);

  localparam int          CW          = $clog2(MAX_FRAME + 1);
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_DATA, S_END, S_DROP} state_t;

  state_t        r_state;
  logic          r_dv, r_er;
  logic [7:0]    r_rxd;
  logic [9:0]    r_dl [DLY];
  logic [63:0]   r_gc;
  logic [7:0]    r_seq;
  logic [2:0]    r_hdr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_hold;
  logic [31:0]   r_crc;
  logic          r_first, r_trunc, r_er_seen, r_lost;
  logic [17:0]   r_din;
  logic          r_wr_en;
  logic [7:0]    r_rx_count;
  logic [15:0]   r_err_count, r_drop_count;

  logic          w_tail_dv, w_tail_er;
  logic [7:0]    w_tail_byte;
  logic          w_lost_now;
  logic          w_crc_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  assign w_tail_dv   = r_dl[DLY-1][9];
  assign w_tail_er   = r_dl[DLY-1][8];
  assign w_tail_byte = r_dl[DLY-1][7:0];
  assign w_lost_now  = r_wr_en & phy.phy_full;
  // The reflected register holds the bit-reversed form of the classic residue.
  assign w_crc_bad   = (rev32(r_crc) != CRC_RESIDUE);

  assign phy.phy_din   = r_din;
  assign phy.phy_wr_en = r_wr_en;
  assign phy_rx_count  = r_rx_count;
  assign err_count     = r_err_count;
  assign drop_count    = r_drop_count;
  assign o_dbg_state   = r_state;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_dv  <= 1'b0;
      r_er  <= 1'b0;
      r_rxd <= 8'h00;
      for (int i = 0; i < DLY; i++) r_dl[i] <= 10'h000;
    end else begin
      r_dv     <= gmii_rx_dv;
      r_er     <= gmii_rx_er;
      r_rxd    <= gmii_rxd;
      r_dl[0]  <= {r_dv, r_er, r_rxd};
      for (int i = 1; i < DLY; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_gc         <= 64'h0;
      r_seq        <= 8'h00;
      r_hdr        <= 3'd0;
      r_cnt        <= '0;
      r_hold       <= 8'h00;
      r_crc        <= 32'hFFFFFFFF;
      r_first      <= 1'b0;
      r_trunc      <= 1'b0;
      r_er_seen    <= 1'b0;
      r_lost       <= 1'b0;
      r_din        <= 18'h0;
      r_wr_en      <= 1'b0;
      r_rx_count   <= 8'h00;
      r_err_count  <= 16'h0;
      r_drop_count <= 16'h0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: if (r_dv && r_rxd == 8'h55) r_state <= S_PRE;
        S_PRE: begin
          if (!r_dv) r_state <= S_IDLE;
          else if (r_rxd == 8'hD5) begin
            r_gc      <= global_counter;
            r_seq     <= r_rx_count;
            r_hdr     <= 3'd0;
            r_cnt     <= '0;
            r_crc     <= 32'hFFFFFFFF;
            r_first   <= 1'b1;
            r_trunc   <= 1'b0;
            r_er_seen <= 1'b0;
            r_lost    <= 1'b0;
            if (phy.phy_afull) begin
              r_state <= S_DROP;
              if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end else r_state <= S_HDR;
          end else if (r_rxd != 8'h55) r_state <= S_IDLE;
        end
        S_HDR: begin
          r_wr_en <= 1'b1;
          r_lost  <= r_lost | w_lost_now;
          case (r_hdr)
            3'd0:    r_din <= {2'b11, r_gc[63:48]};
            3'd1:    r_din <= {2'b11, r_gc[47:32]};
            3'd2:    r_din <= {2'b11, r_gc[31:16]};
            3'd3:    r_din <= {2'b11, r_gc[15:0]};
            default: r_din <= {2'b11, 8'h00, r_seq};
          endcase
          r_hdr <= r_hdr + 3'd1;
          if (r_hdr == 3'd4) r_state <= S_DATA;
        end
        S_DATA: begin
          r_first <= 1'b0;
          r_lost  <= r_lost | w_lost_now;
          // The first tail entry after the header is the SFD itself.
          if (!r_first) begin
            if (!w_tail_dv) r_state <= S_END;
            else begin
              if (w_tail_er) r_er_seen <= 1'b1;
              if (r_cnt == CW'(MAX_FRAME)) r_trunc <= 1'b1;
              else begin
                r_crc <= crc_byte(r_crc, w_tail_byte);
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt[0]) begin
                  r_din   <= {2'b11, r_hold, w_tail_byte};
                  r_wr_en <= 1'b1;
                end else r_hold <= w_tail_byte;
              end
            end
          end
        end
        S_END: begin
          r_wr_en    <= 1'b1;
          r_din      <= r_cnt[0] ? {2'b10, r_hold, 8'h00} : 18'h0;
          r_rx_count <= r_rx_count + 8'd1;
          if ((w_crc_bad || r_er_seen || r_trunc || r_lost || w_lost_now) && r_err_count != 16'hFFFF)
            r_err_count <= r_err_count + 16'd1;
          r_state <= S_IDLE;
        end
        S_DROP: if (!r_dv) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: drives GMII frames and checks the FIFO word stream and counters.
module tb_gmii_rx_framer;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [63:0] global_counter;
  logic [7:0]  phy_rx_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  logic [7:0]  fb[$];

  gmii_rx_framer_if phy ();

  gmii_rx_framer dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .global_counter (global_counter),
    .phy            (phy),
    .phy_rx_count   (phy_rx_count),
    .err_count      (err_count),
    .drop_count     (drop_count),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // FIFO write monitor
  always @(negedge sys_clk) begin
    if (phy.phy_wr_en) got_q.push_back(phy.phy_din);
  end

  // build a frame: len bytes including a standard Ethernet FCS
  task automatic make_frame(input int len, input int seed, input bit bad_fcs);
    logic [31:0] c;
    logic [31:0] fcs;
    fb.delete();
    for (int i = 0; i < len - 4; i++) fb.push_back(8'((i * 13 + seed) & 255));
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      c = c ^ {24'h0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    fcs = ~c;
    fb.push_back(fcs[7:0]);
    fb.push_back(fcs[15:8]);
    fb.push_back(fcs[23:16]);
    fb.push_back(fcs[31:24]);
    if (bad_fcs) fb[len-1] = fb[len-1] ^ 8'h01;
  endtask

  // expected FIFO words for fb
  task automatic build_exp(input logic [63:0] gc, input logic [7:0] seq);
    int n;
    exp_q.delete();
    exp_q.push_back({2'b11, gc[63:48]});
    exp_q.push_back({2'b11, gc[47:32]});
    exp_q.push_back({2'b11, gc[31:16]});
    exp_q.push_back({2'b11, gc[15:0]});
    exp_q.push_back({2'b11, 8'h00, seq});
    n = (fb.size() > 1522) ? 1522 : fb.size();
    for (int i = 0; i + 1 < n; i += 2) exp_q.push_back({2'b11, fb[i], fb[i+1]});
    if (n % 2 == 1) exp_q.push_back({2'b10, fb[n-1], 8'h00});
    else exp_q.push_back(18'h0);
  endtask

  // driver
  task automatic drive_byte(input logic [7:0] b);
    @(negedge sys_clk);
    gmii_rx_dv = 1'b1;
    gmii_rx_er = 1'b0;
    gmii_rxd   = b;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'h00;
    end
  endtask

  task automatic drive_frame(input logic [63:0] gc);
    global_counter = gc;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < fb.size(); i++) drive_byte(fb[i]);
    drive_idle(24);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd = 8'h00;
    global_counter = 64'h0;
    phy.phy_full = 1'b0;
    phy.phy_afull = 1'b0;
    repeat (4) @(negedge sys_clk);
    n_checks++;
    if (phy.phy_wr_en !== 1'b0 || phy.phy_din !== 18'h0) begin
      n_fail++; $display("FAIL reset_fifo got wr_en=%b din=%h want 0/00000", phy.phy_wr_en, phy.phy_din);
    end
    n_checks++;
    if (phy_rx_count !== 8'h00 || err_count !== 16'h0 || drop_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_counts got %h/%h/%h want 00/0000/0000", phy_rx_count, err_count, drop_count);
    end
    n_checks++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got %0d want 0", dbg_state);
    end
    sys_rst = 1'b0;
    drive_idle(4);
  endtask

  task automatic test_good_64();
    got_q.delete();
    make_frame(64, 1, 1'b0);
    build_exp(64'h0011223344556677, 8'h00);
    drive_frame(64'h0011223344556677);
    n_checks++;
    if (got_q.size() !== 38) begin
      n_fail++; $display("FAIL t1_words got %0d want 38", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t1_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (got_q.size() > 0 && got_q[0] !== 18'h30011) begin
      n_fail++; $display("FAIL t1_hdr0 got %h want 30011", got_q[0]);
    end
    n_checks++;
    if (phy_rx_count !== 8'd1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL t1_counts got rx=%0d err=%0d want 1/0", phy_rx_count, err_count);
    end
  endtask

  task automatic test_odd_65();
    got_q.delete();
    make_frame(65, 7, 1'b0);
    build_exp(64'hA5A5_0000_1234_FFFF, 8'h01);
    drive_frame(64'hA5A5_0000_1234_FFFF);
    n_checks++;
    if (got_q.size() !== 38) begin
      n_fail++; $display("FAIL t2_words got %0d want 38", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t2_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (got_q.size() > 4 && got_q[4] !== 18'h30001) begin
      n_fail++; $display("FAIL t2_seq got %h want 30001", got_q[4]);
    end
    n_checks++;
    if (got_q.size() > 0 && got_q[got_q.size()-1][17:16] !== 2'b10) begin
      n_fail++; $display("FAIL t2_endtag got %b want 10", got_q[got_q.size()-1][17:16]);
    end
    n_checks++;
    if (phy_rx_count !== 8'd2 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL t2_counts got rx=%0d err=%0d want 2/0", phy_rx_count, err_count);
    end
  endtask

  task automatic test_bad_fcs();
    got_q.delete();
    make_frame(64, 3, 1'b1);
    build_exp(64'h1, 8'h02);
    drive_frame(64'h1);
    n_checks++;
    if (got_q.size() !== 38) begin
      n_fail++; $display("FAIL t3_words got %0d want 38", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t3_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (phy_rx_count !== 8'd3 || err_count !== 16'd1) begin
      n_fail++; $display("FAIL t3_counts got rx=%0d err=%0d want 3/1", phy_rx_count, err_count);
    end
  endtask

  task automatic test_drop();
    got_q.delete();
    phy.phy_afull = 1'b1;
    make_frame(64, 5, 1'b0);
    drive_frame(64'h2);
    phy.phy_afull = 1'b0;
    n_checks++;
    if (got_q.size() !== 0) begin
      n_fail++; $display("FAIL t4_drop_words got %0d want 0", got_q.size());
    end
    n_checks++;
    if (drop_count !== 16'd1 || phy_rx_count !== 8'd3) begin
      n_fail++; $display("FAIL t4_drop_counts got drop=%0d rx=%0d want 1/3", drop_count, phy_rx_count);
    end
    got_q.delete();
    make_frame(64, 9, 1'b0);
    build_exp(64'h3, 8'h03);
    drive_frame(64'h3);
    n_checks++;
    if (got_q.size() !== 38) begin
      n_fail++; $display("FAIL t4_next_words got %0d want 38", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t4_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (phy_rx_count !== 8'd4 || drop_count !== 16'd1 || err_count !== 16'd1) begin
      n_fail++; $display("FAIL t4_counts got rx=%0d drop=%0d err=%0d want 4/1/1", phy_rx_count, drop_count, err_count);
    end
  endtask

  task automatic test_truncate();
    got_q.delete();
    make_frame(2000, 11, 1'b0);
    build_exp(64'hFEDC_BA98_7654_3210, 8'h04);
    drive_frame(64'hFEDC_BA98_7654_3210);
    n_checks++;
    if (got_q.size() !== 767) begin
      n_fail++; $display("FAIL t5_words got %0d want 767", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t5_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (phy_rx_count !== 8'd5 || err_count !== 16'd2) begin
      n_fail++; $display("FAIL t5_counts got rx=%0d err=%0d want 5/2", phy_rx_count, err_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    make_frame(64, 13, 1'b0);
    global_counter = 64'h4;
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < 20; i++) drive_byte(fb[i]);
    sys_rst = 1'b1;
    for (int i = 20; i < 23; i++) drive_byte(fb[i]);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd = 8'h00;
    got_q.delete();
    drive_idle(24);
    n_checks++;
    if (got_q.size() !== 0) begin
      n_fail++; $display("FAIL t6_after_reset_words got %0d want 0", got_q.size());
    end
    n_checks++;
    if (phy_rx_count !== 8'd0 || err_count !== 16'd0 || drop_count !== 16'd0) begin
      n_fail++; $display("FAIL t6_reset_counts got %0d/%0d/%0d want 0/0/0", phy_rx_count, err_count, drop_count);
    end
    got_q.delete();
    make_frame(64, 17, 1'b0);
    build_exp(64'h0011223344556677, 8'h00);
    drive_frame(64'h0011223344556677);
    n_checks++;
    if (got_q.size() !== 38) begin
      n_fail++; $display("FAIL t6_words got %0d want 38", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL t6_word[%0d] got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (phy_rx_count !== 8'd1 || err_count !== 16'd0) begin
      n_fail++; $display("FAIL t6_counts got rx=%0d err=%0d want 1/0", phy_rx_count, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_good_64();
    test_odd_65();
    test_bad_fcs();
    test_drop();
    test_truncate();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
